// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory-access pipeline stage.
//   mem_kind_t - micro-op memory class carried from execute
//   state_t    - access sequencer states
package mem_pkg;

    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        MK_NONE  = 2'd0,
        MK_LOAD  = 2'd1,
        MK_STORE = 2'd2
    } mem_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Encoding 3 is unused and is treated as a plain pass-through op.
    function automatic logic is_mem_kind(input logic [1:0] kind);
        return (kind == MK_LOAD) || (kind == MK_STORE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on the memory port and flags
// when the wait reaches TIMEOUT.
//   clk, reset - clock, synchronous active-high reset
//   clear      - zero the count (has priority over enable)
//   enable     - count this cycle
//   expired    - this cycle's increment brings the count to TIMEOUT
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Combinational so the waiting state can leave in the same cycle the
    // limit is hit, giving exactly TIMEOUT cycles of request.
    assign expired = enable && ((32'(count_q) + 32'd1) >= TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline stage after execute. Plain ops pass to writeback
// with one cycle of latency; loads/stores run a req/ack memory access while
// holding execute off through mem_blocked.
//   exe_*      - registered execute outputs (valid, result/address, store data,
//                flags, kind, destination, write enable)
//   mem_*      - memory port (req/we/addr/wdata out, ack/rdata in)
//   mem_blocked- stall back to execute
//   wb_*       - writeback outputs, wb_valid pulses once per op
//   mem_err    - sticky: an access timed out waiting for mem_ack
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int          DATA_W  = DATA_W_DEF,
    parameter int          REG_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exe_valid,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [DATA_W-1:0] exe_store_data,
    input  logic [63:0]       exe_rflags,
    input  logic [1:0]        exe_kind,
    input  logic [REG_W-1:0]  exe_dst,
    input  logic              exe_wr_en,
    output logic              mem_blocked,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_dst,
    output logic              wb_wr_en,
    output logic [63:0]       wb_rflags,
    output logic              mem_err
);
    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [REG_W-1:0]    wb_dst_q, wb_dst_d;
    logic                wb_wr_en_q, wb_wr_en_d;
    logic [63:0]         wb_rflags_q, wb_rflags_d;
    logic                mem_err_q, mem_err_d;
    // Writeback attributes of the op in flight, held across the access.
    logic [REG_W-1:0]    op_dst_q, op_dst_d;
    logic                op_wr_en_q, op_wr_en_d;
    logic [63:0]         op_rflags_q, op_rflags_d;

    logic can_accept;
    logic tmo_expired;

    // DONE behaves like IDLE for intake so back-to-back ops lose no cycle.
    assign can_accept  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign mem_blocked = !reset && ((state_q == ST_REQ) ||
                         (can_accept && exe_valid && is_mem_kind(exe_kind)));

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_REQ),
        .enable  (state_q == ST_REQ),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_dst_d    = wb_dst_q;
        wb_wr_en_d  = wb_wr_en_q;
        wb_rflags_d = wb_rflags_q;
        mem_err_d   = mem_err_q;
        op_dst_d    = op_dst_q;
        op_wr_en_d  = op_wr_en_q;
        op_rflags_d = op_rflags_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (exe_valid) begin
                    if (is_mem_kind(exe_kind)) begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (exe_kind == MK_STORE);
                        mem_addr_d  = exe_result;
                        mem_wdata_d = exe_store_data;
                        op_dst_d    = exe_dst;
                        op_wr_en_d  = exe_wr_en;
                        op_rflags_d = exe_rflags;
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_data_d   = exe_result;
                        wb_dst_d    = exe_dst;
                        wb_wr_en_d  = exe_wr_en;
                        wb_rflags_d = exe_rflags;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the same cycle as expiry still completes the access.
                if (mem_ack || tmo_expired) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_dst_d    = op_dst_q;
                    wb_rflags_d = op_rflags_q;
                    if (!mem_ack) begin
                        mem_err_d  = 1'b1;
                        wb_data_d  = '0;
                        wb_wr_en_d = 1'b0;
                    end else if (mem_we_q) begin
                        wb_data_d  = mem_addr_q;
                        wb_wr_en_d = 1'b0;
                    end else begin
                        wb_data_d  = mem_rdata;
                        wb_wr_en_d = op_wr_en_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_dst_q    <= '0;
            wb_wr_en_q  <= 1'b0;
            wb_rflags_q <= '0;
            mem_err_q   <= 1'b0;
            op_dst_q    <= '0;
            op_wr_en_q  <= 1'b0;
            op_rflags_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_dst_q    <= wb_dst_d;
            wb_wr_en_q  <= wb_wr_en_d;
            wb_rflags_q <= wb_rflags_d;
            mem_err_q   <= mem_err_d;
            op_dst_q    <= op_dst_d;
            op_wr_en_q  <= op_wr_en_d;
            op_rflags_q <= op_rflags_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_dst    = wb_dst_q;
    assign wb_wr_en  = wb_wr_en_q;
    assign wb_rflags = wb_rflags_q;
    assign mem_err   = mem_err_q;

endmodule
